// File: rtl/maxnet_sequencer.sv
// Control sequencer for the 4-lane MaxNet winner-take-all datapath.
// Iterates load/multiply/sum until one lane survives, all lanes die, or the iteration limit is hit.
module maxnet_sequencer #(
    parameter int N        = 4,
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 7,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [N-1:0]      pu_active,
    output logic              read,
    output logic              select_y,
    output logic              load_y,
    output logic              load_mult,
    output logic              load_sum,
    output logic              busy,
    output logic              done,
    output logic              winner_valid,
    output logic [IDX_W-1:0]  winner_idx,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_SUM,
        S_CHECK,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  lane_count;
    logic [IDX_W-1:0]  lane_idx;
    logic [ITER_W-1:0] iter_next;
    logic              at_limit;

    always_comb begin
        lane_count = '0;
        lane_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pu_active[i]) begin
                lane_count = lane_count + CNT_W'(1);
                lane_idx   = IDX_W'(i);
            end
        end
    end

    assign iter_next = iter_count + ITER_W'(1);
    assign at_limit  = (iter_next == ITER_W'(MAX_ITER));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        read       = 1'b0;
        select_y   = 1'b0;
        load_y     = 1'b0;
        load_mult  = 1'b0;
        load_sum   = 1'b0;
        done       = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                read       = 1'b1;
                load_y     = 1'b1;
                state_next = S_MULT;
            end
            S_MULT: begin
                load_mult  = 1'b1;
                state_next = S_SUM;
            end
            S_SUM: begin
                load_sum   = 1'b1;
                state_next = S_CHECK;
            end
            S_CHECK: begin
                // pu_active is only decoded here, so X on it in other states never reaches state.
                if (lane_count <= CNT_W'(1) || at_limit) state_next = S_DONE;
                else                                      state_next = S_UPDATE;
            end
            S_UPDATE: begin
                select_y   = 1'b1;
                load_y     = 1'b1;
                state_next = S_MULT;
            end
            S_DONE: begin
                done       = !abort;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    // Results are frozen while abort is high so an aborted run leaves them untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iter_count   <= '0;
            winner_valid <= 1'b0;
            winner_idx   <= '0;
            timeout      <= 1'b0;
        end else if (!abort) begin
            if (state == S_IDLE && start) begin
                iter_count   <= '0;
                winner_valid <= 1'b0;
                winner_idx   <= '0;
                timeout      <= 1'b0;
            end else if (state == S_CHECK) begin
                if (iter_count != ITER_W'(MAX_ITER)) iter_count <= iter_next;
                if (lane_count == CNT_W'(1)) begin
                    winner_valid <= 1'b1;
                    winner_idx   <= lane_idx;
                end else if (lane_count != '0 && at_limit) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Self-checking bench for maxnet_sequencer: directed scenarios plus randomised runs
// checked cycle by cycle against an iteration-level reference model.
module tb_maxnet_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] pu;
    logic       sel;

    logic       a_read, a_sel_y, a_load_y, a_mult, a_sum, a_busy, a_done, a_wv, a_to;
    logic [1:0] a_idx;
    logic [6:0] a_iter;
    logic       b_read, b_sel_y, b_load_y, b_mult, b_sum, b_busy, b_done, b_wv, b_to;
    logic [1:0] b_idx;
    logic [2:0] b_iter;

    logic [6:0] o_strb;
    logic       o_wv, o_to;
    logic [1:0] o_idx;
    logic [6:0] o_iter;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] seq_q[$];

    always #5 clock = ~clock;

    maxnet_sequencer #(.N(4), .MAX_ITER(64), .ITER_W(7)) dut (
        .clock(clock), .reset(reset), .start(start & ~sel), .abort(abort), .pu_active(pu),
        .read(a_read), .select_y(a_sel_y), .load_y(a_load_y), .load_mult(a_mult),
        .load_sum(a_sum), .busy(a_busy), .done(a_done), .winner_valid(a_wv),
        .winner_idx(a_idx), .timeout(a_to), .iter_count(a_iter)
    );

    maxnet_sequencer #(.N(4), .MAX_ITER(4), .ITER_W(3)) dut4 (
        .clock(clock), .reset(reset), .start(start & sel), .abort(abort), .pu_active(pu),
        .read(b_read), .select_y(b_sel_y), .load_y(b_load_y), .load_mult(b_mult),
        .load_sum(b_sum), .busy(b_busy), .done(b_done), .winner_valid(b_wv),
        .winner_idx(b_idx), .timeout(b_to), .iter_count(b_iter)
    );

    assign o_strb = sel ? {b_read, b_sel_y, b_load_y, b_mult, b_sum, b_busy, b_done}
                        : {a_read, a_sel_y, a_load_y, a_mult, a_sum, a_busy, a_done};
    assign o_wv   = sel ? b_wv  : a_wv;
    assign o_to   = sel ? b_to  : a_to;
    assign o_idx  = sel ? b_idx : a_idx;
    assign o_iter = sel ? {4'b0000, b_iter} : a_iter;

    task automatic load_seq(input logic [3:0] first[$]);
        seq_q = first;
        while (seq_q.size() < 64) seq_q.push_back(4'b1111);
    endtask

    // Expected strobe vector {read,select_y,load_y,load_mult,load_sum,busy,done} c edges after start.
    function automatic logic [6:0] exp_strobes(input int c, input int k);
        if (c == 4 * k + 1) return 7'b0000011;
        if (c == 1)         return 7'b1010010;
        case (c % 4)
            1:       return 7'b0110010;
            2:       return 7'b0001010;
            3:       return 7'b0000110;
            default: return 7'b0000010;
        endcase
    endfunction

    task automatic run_job(input string name, input bit use4, input int max_iter,
                           input int abort_at, input bit hold_start);
        int k = 0;
        bit ewv = 0;
        bit eto = 0;
        int eidx = 0;
        logic [3:0] v;
        for (int i = 1; i <= max_iter; i++) begin
            v = seq_q[i-1];
            k = i;
            if ($countones(v) == 1) begin
                ewv = 1;
                for (int b = 0; b < 4; b++) if (v[b]) eidx = b;
                break;
            end
            if ($countones(v) == 0) break;
            if (i == max_iter) begin
                eto = 1;
                break;
            end
        end

        @(negedge clock);
        sel = use4;
        start = 1'b1;
        pu = 'x;
        for (int c = 1; c <= 4 * k + 1; c++) begin
            @(negedge clock);
            if (!hold_start) start = 1'b0;
            n_cmp++;
            if (o_strb !== exp_strobes(c, k)) begin
                n_err++;
                $display("FAIL %s strobes c=%0d got %b exp %b", name, c, o_strb, exp_strobes(c, k));
            end
            n_cmp++;
            if (o_iter !== 7'((c - 1) / 4)) begin
                n_err++;
                $display("FAIL %s iter_count c=%0d got %0d exp %0d", name, c, o_iter, (c - 1) / 4);
            end
            if (c == 1) begin
                n_cmp++;
                if ({o_wv, o_to, o_idx} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL %s cleared_at_start got wv=%b to=%b idx=%0d exp 0", name, o_wv, o_to, o_idx);
                end
            end
            if (c == abort_at) begin
                abort = 1'b1;
                @(negedge clock);
                abort = 1'b0;
                n_cmp++;
                if ({o_strb, o_wv, o_to, o_iter} !== {7'b0, 1'b0, 1'b0, 7'((c - 1) / 4)}) begin
                    n_err++;
                    $display("FAIL %s abort got strb=%b wv=%b to=%b iter=%0d exp strb=0 iter=%0d",
                             name, o_strb, o_wv, o_to, o_iter, (c - 1) / 4);
                end
                for (int j = 0; j < 4; j++) begin
                    @(negedge clock);
                    n_cmp++;
                    if (o_strb !== 7'b0) begin
                        n_err++;
                        $display("FAIL %s post_abort_idle got %b exp 0000000", name, o_strb);
                    end
                end
                return;
            end
            pu = (c % 4 == 0) ? seq_q[c/4 - 1] : 4'bxxxx;
        end

        @(negedge clock);
        pu = 'x;
        n_cmp++;
        if (o_strb !== 7'b0) begin
            n_err++;
            $display("FAIL %s after_done strobes got %b exp 0000000", name, o_strb);
        end
        n_cmp++;
        if ({o_wv, o_idx, o_to, o_iter} !== {ewv, 2'(eidx), eto, 7'(k)}) begin
            n_err++;
            $display("FAIL %s result got wv=%b idx=%0d to=%b iter=%0d exp wv=%b idx=%0d to=%b iter=%0d",
                     name, o_wv, o_idx, o_to, o_iter, ewv, eidx, eto, k);
        end

        if (hold_start) begin
            @(negedge clock);
            n_cmp++;
            if ({o_strb, o_wv, o_to, o_iter} !== {7'b1010010, 1'b0, 1'b0, 7'd0}) begin
                n_err++;
                $display("FAIL %s relaunch got strb=%b wv=%b to=%b iter=%0d exp strb=1010010 cleared",
                         name, o_strb, o_wv, o_to, o_iter);
            end
            start = 1'b0;
            abort = 1'b1;
            @(negedge clock);
            abort = 1'b0;
            n_cmp++;
            if (o_strb !== 7'b0) begin
                n_err++;
                $display("FAIL %s relaunch_abort got %b exp 0000000", name, o_strb);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pu    = 'x;
        sel   = 1'b0;
        #2;
        n_cmp++;
        if ({o_strb, o_wv, o_idx, o_to, o_iter} !== 18'b0) begin
            n_err++;
            $display("FAIL reset_state got %b exp 0", {o_strb, o_wv, o_idx, o_to, o_iter});
        end
        @(negedge clock);
        reset = 1'b1;
        load_seq('{4'b0010});
        run_job("pre_reset_run", 1'b0, 64, -1, 1'b0);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({o_wv, o_idx, o_to, o_iter} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_clears_results got wv=%b idx=%0d to=%b iter=%0d exp 0", o_wv, o_idx, o_to, o_iter);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if ({a_read, a_load_y, a_busy} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_in_load_pre got read/load_y/busy=%b exp 111", {a_read, a_load_y, a_busy});
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({a_read, a_load_y, a_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_in_load_async got read/load_y/busy=%b exp 000", {a_read, a_load_y, a_busy});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({o_strb, o_wv, o_idx, o_to, o_iter} !== 18'b0) begin
            n_err++;
            $display("FAIL reset_release_idle got %b exp 0", {o_strb, o_wv, o_idx, o_to, o_iter});
        end
    endtask

    task automatic test_single_winner();
        load_seq('{4'b0100});
        run_job("winner_lane2", 1'b0, 64, -1, 1'b0);
    endtask

    task automatic test_multi_iter();
        load_seq('{4'b1111, 4'b1111, 4'b0001});
        run_job("three_iter", 1'b0, 64, -1, 1'b0);
    endtask

    task automatic test_timeout();
        load_seq('{4'b0011, 4'b0011, 4'b0011, 4'b0011});
        run_job("timeout_limit4", 1'b1, 4, -1, 1'b0);
        load_seq('{4'b0011, 4'b0011, 4'b0011, 4'b1000});
        run_job("winner_on_limit", 1'b1, 4, -1, 1'b0);
    endtask

    task automatic test_extinct();
        load_seq('{4'b0000});
        run_job("all_dead", 1'b0, 64, -1, 1'b0);
    endtask

    task automatic test_abort();
        load_seq('{4'b1000});
        run_job("before_abort", 1'b0, 64, -1, 1'b0);
        load_seq('{4'b1111, 4'b1111, 4'b1111});
        run_job("abort_in_sum", 1'b0, 64, 7, 1'b0);
        load_seq('{4'b0110, 4'b0100});
        run_job("after_abort", 1'b0, 64, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        load_seq('{4'b1010, 4'b0010});
        run_job("start_held", 1'b0, 64, -1, 1'b1);
    endtask

    task automatic test_random();
        bit use4;
        for (int r = 0; r < 24; r++) begin
            use4 = 1'($urandom_range(0, 1));
            seq_q.delete();
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0) seq_q.push_back(4'($urandom_range(0, 15)));
                else seq_q.push_back(4'($urandom_range(0, 15)) | 4'b0011);
            end
            run_job(use4 ? "random_lim4" : "random_lim64", use4, use4 ? 4 : 64, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_winner();
        test_multi_iter();
        test_timeout();
        test_extinct();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
